// File: rtl/mainfsm.sv
// mainfsm: multicycle RV32I control FSM with a memory wait counter and an instruction-done pulse.
// Define MAINFSM_TRAP_EN to send unknown opcodes to a sticky TRAP state that raises `illegal`.
module mainfsm #(
  parameter int MEM_LAT = 0,
  parameter int SW      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [6:0]    op,
  input  logic          Zero,
  output logic          PCWrite,
  output logic          AdrSrc,
  output logic          IRWrite,
  output logic          MemWrite,
  output logic          RegWrite,
  output logic [1:0]    ResultSrc,
  output logic [1:0]    ALUSrcA,
  output logic [1:0]    ALUSrcB,
  output logic [1:0]    ALUOp,
  output logic [1:0]    ImmSrc,
  output logic          instr_done,
  output logic          illegal,
  output logic [SW-1:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
  } ctrl_t;

  localparam logic [3:0] LAT    = 4'(MEM_LAT);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // Moore decode; `last` marks the final cycle of a memory state so strobes fire exactly once.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [3:0] w);
    ctrl_t c;
    logic  last;
    c    = '0;
    last = (w == LAT);
    case (s)
      S_FETCH: begin
        c.ir_write   = last;
        c.pc_update  = last;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD: c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src    = 1'b1;
        c.mem_write  = last;
        c.instr_done = last;
      end
      S_EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a  = 2'b10;
        c.alu_op     = 2'b01;
        c.branch     = 1'b1;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t     state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       mem_wait;
`ifdef MAINFSM_TRAP_EN
  logic       illegal_q, illegal_d;
`endif

  always_comb begin
    state_d  = state_q;
    wcnt_d   = 4'd0;
    mem_wait = (wcnt_q < LAT);
    case (state_q)
      S_FETCH: begin
        if (mem_wait) wcnt_d = wcnt_q + 4'd1;
        else          state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
`ifdef MAINFSM_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:  state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_wait) wcnt_d = wcnt_q + 4'd1;
        else          state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        if (mem_wait) wcnt_d = wcnt_q + 4'd1;
        else          state_d = S_FETCH;
      end
      S_MEMWB, S_ALUWB, S_BEQ:  state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL:  state_d = S_ALUWB;
      S_TRAP:                   state_d = S_TRAP;
      default:                  state_d = S_FETCH;
    endcase
    // Outputs are registered from the next state so they stay glitch-free Moore values.
    ctrl_d = decode_ctrl(state_d, wcnt_d);
`ifdef MAINFSM_TRAP_EN
    illegal_d = illegal_q | (state_d == S_TRAP);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wcnt_q    <= 4'd0;
      ctrl_q    <= decode_ctrl(S_FETCH, 4'd0);
`ifdef MAINFSM_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      ctrl_q    <= ctrl_d;
`ifdef MAINFSM_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

`ifdef MAINFSM_TRAP_EN
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Zero only matters while the branch strobe is up, i.e. in BEQ.
  assign PCWrite    = ctrl_q.pc_update | (ctrl_q.branch & Zero);
  assign AdrSrc     = ctrl_q.adr_src;
  assign IRWrite    = ctrl_q.ir_write;
  assign MemWrite   = ctrl_q.mem_write;
  assign RegWrite   = ctrl_q.reg_write;
  assign ResultSrc  = ctrl_q.result_src;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign ALUOp      = ctrl_q.alu_op;
  assign instr_done = ctrl_q.instr_done;
  assign state      = SW'(state_q);

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_mainfsm.sv
// tb_mainfsm: checks mainfsm at MEM_LAT 0, 2 and 3 against a per-instruction output-sequence model.
module tb_mainfsm;

  typedef logic [20:0] vec_t;

  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5;
  localparam int ER = 6, AWB = 7, EI = 8, JL = 9, BQ = 10, TR = 11;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SWOP = 7'b0100011;
  localparam logic [6:0] ROP  = 7'b0110011;
  localparam logic [6:0] IOP  = 7'b0010011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] BAD  = 7'b1111111;

  logic       clk = 1'b0;
  logic [2:0] rst;
  logic [6:0] op;
  logic       zero;

  logic [2:0] pcw, adr, irw, mw, rw, done, ill;
  logic [1:0] rs [3];
  logic [1:0] a [3];
  logic [1:0] b [3];
  logic [1:0] aop [3];
  logic [1:0] imm [3];
  logic [3:0] st [3];

  int   checks = 0;
  int   errors = 0;
  int   act = 0;
  int   cyc_cnt, irw_cnt, mw_cnt, rw_cnt, done_cnt;
  vec_t exp_q[$];

  always #5 clk = ~clk;

  mainfsm #(.MEM_LAT(0), .SW(4)) u0 (
    .clk(clk), .reset(rst[0]), .op(op), .Zero(zero),
    .PCWrite(pcw[0]), .AdrSrc(adr[0]), .IRWrite(irw[0]), .MemWrite(mw[0]),
    .RegWrite(rw[0]), .ResultSrc(rs[0]), .ALUSrcA(a[0]), .ALUSrcB(b[0]),
    .ALUOp(aop[0]), .ImmSrc(imm[0]), .instr_done(done[0]), .illegal(ill[0]),
    .state(st[0])
  );

  mainfsm #(.MEM_LAT(2), .SW(4)) u1 (
    .clk(clk), .reset(rst[1]), .op(op), .Zero(zero),
    .PCWrite(pcw[1]), .AdrSrc(adr[1]), .IRWrite(irw[1]), .MemWrite(mw[1]),
    .RegWrite(rw[1]), .ResultSrc(rs[1]), .ALUSrcA(a[1]), .ALUSrcB(b[1]),
    .ALUOp(aop[1]), .ImmSrc(imm[1]), .instr_done(done[1]), .illegal(ill[1]),
    .state(st[1])
  );

  mainfsm #(.MEM_LAT(3), .SW(4)) u2 (
    .clk(clk), .reset(rst[2]), .op(op), .Zero(zero),
    .PCWrite(pcw[2]), .AdrSrc(adr[2]), .IRWrite(irw[2]), .MemWrite(mw[2]),
    .RegWrite(rw[2]), .ResultSrc(rs[2]), .ALUSrcA(a[2]), .ALUSrcB(b[2]),
    .ALUOp(aop[2]), .ImmSrc(imm[2]), .instr_done(done[2]), .illegal(ill[2]),
    .state(st[2])
  );

  function automatic vec_t pack(int s, bit p, bit ad, bit ir, bit m, bit r,
                                logic [1:0] rsrc, logic [1:0] sa, logic [1:0] sb,
                                logic [1:0] ao, logic [1:0] im, bit dn, bit il);
    logic [3:0] s4;
    s4 = 4'(s);
    return {s4, p, ad, ir, m, r, rsrc, sa, sb, ao, im, dn, il};
  endfunction

  function automatic vec_t dut_vec(int i);
    return {st[i], pcw[i], adr[i], irw[i], mw[i], rw[i], rs[i], a[i], b[i],
            aop[i], imm[i], done[i], ill[i]};
  endfunction

  function automatic logic [1:0] imm_of(logic [6:0] o);
    if (o == SWOP) return 2'b01;
    if (o == BEQ)  return 2'b10;
    if (o == JAL)  return 2'b11;
    return 2'b00;
  endfunction

  // Output table for each named state; `last` is the final cycle of a memory access.
  function automatic vec_t out_for(int s, bit last, bit z, logic [6:0] o);
    logic [1:0] im;
    im = imm_of(o);
    case (s)
      F:   return pack(F,   last, 0, last, 0,    0, 2'b10, 2'b00, 2'b10, 2'b00, im, 0,    0);
      D:   return pack(D,   0,    0, 0,    0,    0, 2'b00, 2'b01, 2'b01, 2'b00, im, 0,    0);
      MA:  return pack(MA,  0,    0, 0,    0,    0, 2'b00, 2'b10, 2'b01, 2'b00, im, 0,    0);
      MR:  return pack(MR,  0,    1, 0,    0,    0, 2'b00, 2'b00, 2'b00, 2'b00, im, 0,    0);
      MWB: return pack(MWB, 0,    0, 0,    0,    1, 2'b01, 2'b00, 2'b00, 2'b00, im, 1,    0);
      MW:  return pack(MW,  0,    1, 0,    last, 0, 2'b00, 2'b00, 2'b00, 2'b00, im, last, 0);
      ER:  return pack(ER,  0,    0, 0,    0,    0, 2'b00, 2'b10, 2'b00, 2'b10, im, 0,    0);
      EI:  return pack(EI,  0,    0, 0,    0,    0, 2'b00, 2'b10, 2'b01, 2'b10, im, 0,    0);
      AWB: return pack(AWB, 0,    0, 0,    0,    1, 2'b00, 2'b00, 2'b00, 2'b00, im, 1,    0);
      JL:  return pack(JL,  1,    0, 0,    0,    0, 2'b00, 2'b01, 2'b10, 2'b00, im, 0,    0);
      BQ:  return pack(BQ,  z,    0, 0,    0,    0, 2'b00, 2'b10, 2'b00, 2'b01, im, 1,    0);
      default: return pack(TR, 0, 0, 0,    0,    0, 2'b00, 2'b00, 2'b00, 2'b00, im, 0,    1);
    endcase
  endfunction

  task automatic push_mem(int s, int lat, bit z, logic [6:0] o);
    for (int k = 0; k <= lat; k++) exp_q.push_back(out_for(s, k == lat, z, o));
  endtask

  // Whole-instruction state walk derived from the opcode class.
  task automatic push_instr(int lat, logic [6:0] o, bit z);
    push_mem(F, lat, z, o);
    exp_q.push_back(out_for(D, 0, z, o));
    case (o)
      LW: begin
        exp_q.push_back(out_for(MA, 0, z, o));
        push_mem(MR, lat, z, o);
        exp_q.push_back(out_for(MWB, 0, z, o));
      end
      SWOP: begin
        exp_q.push_back(out_for(MA, 0, z, o));
        push_mem(MW, lat, z, o);
      end
      ROP: begin
        exp_q.push_back(out_for(ER, 0, z, o));
        exp_q.push_back(out_for(AWB, 0, z, o));
      end
      IOP: begin
        exp_q.push_back(out_for(EI, 0, z, o));
        exp_q.push_back(out_for(AWB, 0, z, o));
      end
      JAL: begin
        exp_q.push_back(out_for(JL, 0, z, o));
        exp_q.push_back(out_for(AWB, 0, z, o));
      end
      BEQ: exp_q.push_back(out_for(BQ, 0, z, o));
      default: begin
`ifdef MAINFSM_TRAP_EN
        for (int k = 0; k < 20; k++) exp_q.push_back(out_for(TR, 0, z, o));
`endif
      end
    endcase
  endtask

  task automatic check_int(string name, int got, int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  task automatic check_vec(string name, vec_t got, vec_t expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, expv);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout left=%0d", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic clear_counts();
    cyc_cnt = 0; irw_cnt = 0; mw_cnt = 0; rw_cnt = 0; done_cnt = 0;
  endtask

  task automatic run_instr(int lat, logic [6:0] o, bit z);
    clear_counts();
    op   = o;
    zero = z;
    push_instr(lat, o, z);
    wait_drain();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      vec_t g;
      e = exp_q.pop_front();
      g = dut_vec(act);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL cycle_vec inst=%0d t=%0t got=%h expected=%h", act, $time, g, e);
      end
      cyc_cnt++;
      irw_cnt  += int'(irw[act]);
      mw_cnt   += int'(mw[act]);
      rw_cnt   += int'(rw[act]);
      done_cnt += int'(done[act]);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst  = 3'b111;
    op   = 7'b0000000;
    zero = 1'b0;
    clear_counts();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_vec("reset_lat0", dut_vec(0), out_for(F, 1, 0, 7'b0000000));
    check_vec("reset_lat2", dut_vec(1), out_for(F, 0, 0, 7'b0000000));

    // MEM_LAT = 0
    act = 0;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    run_instr(0, LW, 0);
    check_int("lw_l0_cycles", cyc_cnt, 5);
    check_int("lw_l0_done", done_cnt, 1);
    check_int("lw_l0_regwrite", rw_cnt, 1);
    run_instr(0, ROP, 1);
    run_instr(0, IOP, 0);
    run_instr(0, JAL, 1);
    check_int("jal_l0_cycles", cyc_cnt, 4);
    run_instr(0, BEQ, 1);
    check_int("beq_l0_cycles", cyc_cnt, 3);
    run_instr(0, BEQ, 0);
    run_instr(0, SWOP, 0);
    check_int("sw_l0_memwrite", mw_cnt, 1);
    run_instr(0, BAD, 0);
    check_int("bad_done", done_cnt, 0);
`ifdef MAINFSM_TRAP_EN
    check_int("bad_illegal", int'(ill[0]), 1);
    check_int("bad_state", int'(st[0]), 11);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
`else
    check_int("bad_illegal", int'(ill[0]), 0);
    check_int("bad_state", int'(st[0]), 0);
`endif
    run_instr(0, LW, 0);

    // MEM_LAT = 2
    rst[0] = 1'b1;
    act = 1;
    rst[1] = 1'b0;
    run_instr(2, SWOP, 0);
    check_int("sw_l2_cycles", cyc_cnt, 8);
    check_int("sw_l2_irwrite", irw_cnt, 1);
    check_int("sw_l2_memwrite", mw_cnt, 1);
    check_int("sw_l2_done", done_cnt, 1);
    run_instr(2, LW, 0);
    check_int("lw_l2_cycles", cyc_cnt, 9);
    run_instr(2, BEQ, 1);
    check_int("beq_l2_cycles", cyc_cnt, 5);

    // MEM_LAT = 3, reset in the middle of MEMREAD
    rst[1] = 1'b1;
    act = 2;
    rst[2] = 1'b0;
    op = LW;
    zero = 1'b0;
    clear_counts();
    push_mem(F, 3, 0, LW);
    exp_q.push_back(out_for(D, 0, 0, LW));
    exp_q.push_back(out_for(MA, 0, 0, LW));
    exp_q.push_back(out_for(MR, 0, 0, LW));
    exp_q.push_back(out_for(MR, 0, 0, LW));
    wait_drain();
    check_int("pre_reset_state", int'(st[2]), 3);
    rst[2] = 1'b1;
    #1;
    check_int("async_state", int'(st[2]), 0);
    check_int("async_wcnt", int'(u2.wcnt_q), 0);
    check_int("async_irwrite", int'(irw[2]), 0);
    check_int("async_pcwrite", int'(pcw[2]), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_int("held_regwrite", int'(rw[2]), 0);
    end
    @(posedge clk); #1;
    rst[2] = 1'b0;
    run_instr(3, SWOP, 0);
    check_int("sw_l3_cycles", cyc_cnt, 10);
    check_int("sw_l3_memwrite", mw_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mainfsm.md
# mainfsm

Multicycle successor to `maindec`: a Moore control FSM that sequences each RV32I instruction over several cycles on a shared memory/ALU datapath, replacing single-cycle decode. Sits in the controller beside `aludec`, which consumes `ALUOp`; it drives datapath muxes and register/memory write enables. Adds parametrised memory latency (wait counter), an instruction-done pulse and an optional illegal-opcode trap.

## Interface
- `MEM_LAT`, default 0: extra wait cycles per memory access (0..15).
- `SW`, default 4: width of `state` debug output; fixed at 4 (11–12 states).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `op` in 7: `Instr[6:0]` from the instruction register.
- `Zero` in 1: ALU zero flag (used only in BEQ).
- `PCWrite` out 1: `PCUpdate | (Branch & Zero)`.
- `AdrSrc` out 1: 0 = PC, 1 = ALU result to memory address.
- `IRWrite` out 1: load instruction register.
- `MemWrite` out 1: data memory write enable.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 RD1.
- `ALUSrcB` out 2: 00 RD2, 01 ImmExt, 10 constant 4.
- `ALUOp` out 2: to `aludec`.
- `ImmSrc` out 2: combinational from `op`: lw/I-type 00, sw 01, beq 10, jal 11, others 00.
- `instr_done` out 1: one-cycle pulse on the last cycle of each instruction.
- `illegal` out 1: sticky trap flag.
- `state` out SW: current state encoding (debug).

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10, TRAP 11.
- Transitions: FETCH→DECODE (after wait); DECODE by `op`: 0000011/0100011→MEMADR, 0110011→EXECR, 0010011→EXECI, 1101111→JAL, 1100011→BEQ, other→see Configuration. MEMADR→MEMREAD (lw) or MEMWRITE (sw), selected by `op[5]`. MEMREAD→MEMWB (after wait). MEMWB, MEMWRITE (after wait), ALUWB, BEQ→FETCH. EXECR, EXECI→ALUWB. JAL→ALUWB.
- Outputs are Moore; unlisted signals are 0:
  - FETCH: `AdrSrc`=0, `IRWrite`=1*, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=10, `PCUpdate`=1*.
  - DECODE: A=01, B=01, `ALUOp`=00.
  - MEMADR: A=10, B=01, `ALUOp`=00.
  - MEMREAD: `ResultSrc`=00, `AdrSrc`=1.
  - MEMWB: `ResultSrc`=01, `RegWrite`=1.
  - MEMWRITE: `ResultSrc`=00, `AdrSrc`=1, `MemWrite`=1*.
  - EXECR: A=10, B=00, `ALUOp`=10.
  - EXECI: A=10, B=01, `ALUOp`=10.
  - ALUWB: `ResultSrc`=00, `RegWrite`=1.
  - JAL: A=01, B=10, `ALUOp`=00, `ResultSrc`=00, `PCUpdate`=1.
  - BEQ: A=10, B=00, `ALUOp`=01, `ResultSrc`=00, `Branch`=1.
- \* Memory states FETCH/MEMREAD/MEMWRITE: a wait counter `wcnt` (4 bits) counts 0..MEM_LAT; the state is held while `wcnt`<MEM_LAT. Starred strobes assert only when `wcnt`==MEM_LAT (final cycle), so PC/IR/memory update exactly once. The address mux outputs are held for all cycles. `wcnt` clears on every state change.
- `instr_done`=1 in MEMWB, ALUWB, BEQ and final-cycle MEMWRITE.

## Timing
- Reset (async assert, synchronous release on next edge): state=FETCH, `wcnt`=0, `illegal`=0. Outputs during reset are FETCH values; `IRWrite`/`PCWrite` are 1 if MEM_LAT=0, else 0.
- Cycle counts with MEM_LAT=L: lw 5+2L, sw 4+2L, R/I 4+L, jal 4+L, beq 3+L.
- Reset asserted mid-instruction aborts immediately to FETCH with no further strobes.
- `Zero` is sampled only combinationally in BEQ; it is ignored in all other states.

## Configuration
- `MAINFSM_TRAP_EN` defined: an unknown opcode in DECODE goes to TRAP; TRAP holds all enables 0, `illegal`=1 and never exits until `reset`.
- Undefined: an unknown opcode in DECODE goes to FETCH (treated as NOP, no writes, no `instr_done`); TRAP is unreachable and `illegal` is tied 0.

## Test plan
- MEM_LAT=0, op=0000011: state 0→1→2→3→4→0; `RegWrite`=1 only in state 4 with `ResultSrc`=01; `instr_done` pulses once.
- MEM_LAT=2, op=0100011: FETCH held 3 cycles, `IRWrite` high only in the 3rd; MEMWRITE held 3 cycles with `MemWrite` high exactly 1 cycle; 8 cycles total.
- op=1100011 with Zero=1 then Zero=0: `PCWrite`=1 in BEQ only for Zero=1; `ALUOp`=01.
- op=1101111: JAL shows A=01, B=10, `PCWrite`=1, then ALUWB `RegWrite`=1.
- op=1111111: with the macro, state 11 and `illegal`=1 held for 20 cycles, all enables 0; without it, DECODE→FETCH and `illegal`=0.
- Assert `reset` during MEMREAD with MEM_LAT=3: state=0 and `wcnt`=0 immediately (before clock edge); no `RegWrite`.
